subset_sum_scheduler: RTL and testbench

Round-robin job scheduler that shares one `Full_Node_Tree` subset-sum solver among `N_of_requesters` clients. It accepts one job (numbers plus target) at a time through a valid/ready handshake and launches the solver with a one-cycle start pulse. It waits for the solver's done edge, or for a timeout, and returns the result to the granted requester through a valid/ack handshake. It sits between the client logic and the solver and is the only driver of the solver's inputs.

---
 rtl/subset_sum_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_subset_sum_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subset_sum_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : subset_sum_scheduler
// Purpose  : Round-robin front end that shares one subset-sum solver among
//            several clients. One job (numbers + target) is accepted at a
//            time, the solver is launched with a single-cycle start pulse,
//            and the result (or a timeout) is returned to the granted client
//            through a valid/ack handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                   rising-edge clock
//   rst                   synchronous active-high reset
//   req_valid_i           per-client job request
//   req_ready_o           one-hot acceptance (IDLE only, combinational)
//   req_numbers_flat_i    client i numbers at slice i
//   req_target_i          client i target at slice i
//   resp_valid_o          one-hot result valid
//   resp_isTargetMet_o    result bit, gated by resp_valid_o
//   resp_timeout_o        timeout flag, gated by resp_valid_o
//   resp_ack_i            client consumes result
//   solver_numbers_flat_o numbers to solver
//   solver_target_o       target to solver
//   solver_en_o           solver enable (LAUNCH and WAIT)
//   solver_start_o        one-cycle launch pulse
//   solver_busy_i         solver status (informational only)
//   solver_done_i         solver completion level
//   solver_isTargetMet_i  solver result
//   sched_busy_o          high in every state except IDLE
//   grant_id_o            index of current / last granted client
// ============================================================================
module subset_sum_scheduler #(
  parameter  int N_of_numbers    = 3,
  parameter  int N_of_bits       = 4,
  parameter  int N_of_requesters = 4,
  parameter  int TIMEOUT_CYCLES  = 1024,
  localparam int TW = $clog2(N_of_numbers * (2**N_of_bits - 1)) + 1,
  localparam int IW = (N_of_requesters > 1) ? $clog2(N_of_requesters) : 1,
  localparam int NB = N_of_numbers * N_of_bits
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_of_requesters-1:0]      req_valid_i,
  output logic [N_of_requesters-1:0]      req_ready_o,
  input  logic [N_of_requesters*NB-1:0]   req_numbers_flat_i,
  input  logic [N_of_requesters*TW-1:0]   req_target_i,
  output logic [N_of_requesters-1:0]      resp_valid_o,
  output logic [N_of_requesters-1:0]      resp_isTargetMet_o,
  output logic [N_of_requesters-1:0]      resp_timeout_o,
  input  logic [N_of_requesters-1:0]      resp_ack_i,
  output logic [NB-1:0]                   solver_numbers_flat_o,
  output logic [TW-1:0]                   solver_target_o,
  output logic                            solver_en_o,
  output logic                            solver_start_o,
  input  logic                            solver_busy_i,
  input  logic                            solver_done_i,
  input  logic                            solver_isTargetMet_i,
  output logic                            sched_busy_o,
  output logic [IW-1:0]                   grant_id_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [NB-1:0]   numbers_q, numbers_d;
  logic [TW-1:0]   target_q, target_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            met_q, met_d;
  logic            timeout_q, timeout_d;
  logic            done_q;

  // Round-robin selection results
  logic [IW-1:0]   sel;
  logic            any_req;
  logic            done_rise;

  // Busy is status only; it intentionally never steers the FSM.
  logic            unused_busy;
  assign unused_busy = solver_busy_i;

  // --------------------------------------------------------------------------
  // Round-robin arbiter: walk from rr_q upward (wrapping) and keep the first
  // requester found. Iterating from the far end lets the nearest one win.
  // --------------------------------------------------------------------------
  always_comb begin
    sel     = '0;
    any_req = 1'b0;
    for (int k = N_of_requesters - 1; k >= 0; k--) begin
      logic [IW-1:0] cand;
      cand = IW'((int'(rr_q) + k) % N_of_requesters);
      if (req_valid_i[cand]) begin
        sel     = cand;
        any_req = 1'b1;
      end
    end
  end

  // done_q follows the solver's done level every cycle, including LAUNCH, so
  // a done level still held from the previous job is never seen as an edge.
  assign done_rise = solver_done_i & ~done_q;

  // --------------------------------------------------------------------------
  // Next-state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_d           = rr_q;
    numbers_d      = numbers_q;
    target_d       = target_q;
    cnt_d          = cnt_q;
    met_d          = met_q;
    timeout_d      = timeout_q;
    req_ready_o    = '0;
    solver_start_o = 1'b0;
    solver_en_o    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          req_ready_o[sel] = 1'b1;
          grant_d          = sel;
          rr_d             = IW'((int'(sel) + 1) % N_of_requesters);
          numbers_d        = req_numbers_flat_i[int'(sel)*NB +: NB];
          target_d         = req_target_i[int'(sel)*TW +: TW];
          state_d          = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        solver_start_o = 1'b1;
        solver_en_o    = 1'b1;
        cnt_d          = '0;
        state_d        = S_WAIT;
      end

      S_WAIT: begin
        solver_en_o = 1'b1;
        cnt_d       = cnt_q + 1'b1;
        // A real completion beats a timeout landing on the same cycle.
        if (done_rise) begin
          met_d     = solver_isTargetMet_i;
          timeout_d = 1'b0;
          state_d   = S_RESPOND;
        end else if (cnt_q == CNT_LIM) begin
          met_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_RESPOND;
        end
      end

      S_RESPOND: begin
        // Only the granted client's ack releases the result.
        if (resp_ack_i[grant_q]) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Response outputs: one-hot at the granted index while in RESPOND.
  // --------------------------------------------------------------------------
  always_comb begin
    resp_valid_o = '0;
    if (state_q == S_RESPOND) begin
      resp_valid_o[grant_q] = 1'b1;
    end
  end

  assign resp_isTargetMet_o    = resp_valid_o & {N_of_requesters{met_q}};
  assign resp_timeout_o        = resp_valid_o & {N_of_requesters{timeout_q}};
  assign solver_numbers_flat_o = numbers_q;
  assign solver_target_o       = target_q;
  assign sched_busy_o          = (state_q != S_IDLE);
  assign grant_id_o            = grant_q;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      numbers_q <= '0;
      target_q  <= '0;
      cnt_q     <= '0;
      met_q     <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      numbers_q <= numbers_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      met_q     <= met_d;
      timeout_q <= timeout_d;
      done_q    <= solver_done_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_subset_sum_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_subset_sum_scheduler
// Purpose  : Self-checking bench for subset_sum_scheduler. A behavioural
//            solver model answers each launched job after a programmable
//            delay; directed job vectors plus hand-written sequences cover
//            round-robin order, backpressure, stale done and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_subset_sum_scheduler;

  localparam int NN    = 3;
  localparam int NBITS = 4;
  localparam int NR    = 4;
  localparam int T     = 16;
  localparam int NB    = NN * NBITS;
  localparam int TW    = $clog2(NN * (2**NBITS - 1)) + 1;
  localparam int IW    = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_ready;
  logic [NR*NB-1:0]   req_numbers_flat;
  logic [NR*TW-1:0]   req_target;
  logic [NR-1:0]      resp_valid;
  logic [NR-1:0]      resp_isTargetMet;
  logic [NR-1:0]      resp_timeout;
  logic [NR-1:0]      resp_ack;
  logic [NB-1:0]      solver_numbers_flat;
  logic [TW-1:0]      solver_target;
  logic               solver_en;
  logic               solver_start;
  logic               solver_busy;
  logic               solver_done;
  logic               solver_met;
  logic               sched_busy;
  logic [IW-1:0]      grant_id;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  subset_sum_scheduler #(
    .N_of_numbers    (NN),
    .N_of_bits       (NBITS),
    .N_of_requesters (NR),
    .TIMEOUT_CYCLES  (T)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .req_valid_i           (req_valid),
    .req_ready_o           (req_ready),
    .req_numbers_flat_i    (req_numbers_flat),
    .req_target_i          (req_target),
    .resp_valid_o          (resp_valid),
    .resp_isTargetMet_o    (resp_isTargetMet),
    .resp_timeout_o        (resp_timeout),
    .resp_ack_i            (resp_ack),
    .solver_numbers_flat_o (solver_numbers_flat),
    .solver_target_o       (solver_target),
    .solver_en_o           (solver_en),
    .solver_start_o        (solver_start),
    .solver_busy_i         (solver_busy),
    .solver_done_i         (solver_done),
    .solver_isTargetMet_i  (solver_met),
    .sched_busy_o          (sched_busy),
    .grant_id_o            (grant_id)
  );

  // --------------------------------------------------------------------------
  // Solver model: done rises sv_delay cycles after the start cycle (0 = never);
  // an old done level survives sv_hold cycles past start (0 = drops at once).
  // --------------------------------------------------------------------------
  int sv_delay = 0;
  int sv_hold  = 0;
  int m_cnt;
  int m_hcnt;

  function automatic logic subset(input logic [NB-1:0] n, input logic [TW-1:0] t);
    logic hit;
    hit = 1'b0;
    for (int m = 1; m < (1 << NN); m++) begin
      int s;
      s = 0;
      for (int i = 0; i < NN; i++)
        if (m[i]) s += int'(n[i*NBITS +: NBITS]);
      if (s == int'(t)) hit = 1'b1;
    end
    return hit;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      solver_done <= 1'b0;
      solver_met  <= 1'b0;
      m_cnt       <= 0;
      m_hcnt      <= 0;
    end else if (solver_start) begin
      m_hcnt <= sv_hold;
      if (sv_hold == 0) solver_done <= 1'b0;
      m_cnt  <= (sv_delay > 0) ? sv_delay - 1 : 0;
    end else begin
      if (m_hcnt > 0) begin
        m_hcnt <= m_hcnt - 1;
        if (m_hcnt == 1) solver_done <= 1'b0;
      end
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          solver_done <= 1'b1;
          solver_met  <= subset(solver_numbers_flat, solver_target);
        end
      end
    end
  end

  assign solver_busy = (m_cnt > 0);

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [NB-1:0] pk(input int a, input int b, input int c);
    return {4'(c), 4'(b), 4'(a)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic ack_job(input int g);
    resp_ack = oh(g);
    @(posedge clk); #1;
    resp_ack = '0;
    #1;
    chk("idle_after_ack", 32'({sched_busy, resp_valid}), 32'd0);
    chk("grant_held", 32'(grant_id), 32'(g));
  endtask

  // Present a job, check acceptance, launch, latency and result.
  task automatic run_job(input int client, input logic [NB-1:0] nums,
                         input logic [TW-1:0] tgt, input int delay, input int hold,
                         input logic exp_met, input logic exp_to,
                         input logic [NR-1:0] vmask, input int exp_grant,
                         input bit drop_valid, input bit do_ack);
    int lat;
    int exp_lat;
    bit seen;
    sv_delay = delay;
    sv_hold  = hold;
    req_numbers_flat[client*NB +: NB] = nums;
    req_target[client*TW +: TW]       = tgt;
    req_valid = vmask;
    #1;
    chk("ready_onehot", 32'(req_ready), 32'(oh(exp_grant)));
    @(posedge clk); #1;
    if (drop_valid) req_valid[exp_grant] = 1'b0;
    #1;
    chk("launch_start_en_busy", 32'({solver_start, solver_en, sched_busy}), 32'h7);
    chk("launch_ready_zero", 32'(req_ready), 32'd0);
    chk("grant_id", 32'(grant_id), 32'(exp_grant));
    chk("job_numbers", 32'(solver_numbers_flat), 32'(nums));
    chk("job_target", 32'(solver_target), 32'(tgt));
    exp_lat = (delay > 0 && delay <= T) ? delay + 1 : T + 1;
    lat  = 0;
    seen = 1'b0;
    for (int c = 1; c <= T + 8 && !seen; c++) begin
      @(posedge clk); #1;
      if (c == 1) chk("start_one_cycle", 32'(solver_start), 32'd0);
      if (resp_valid != '0) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    chk("resp_latency", 32'(lat), 32'(exp_lat));
    chk("resp_valid", 32'(resp_valid), 32'(oh(exp_grant)));
    chk("resp_met", 32'(resp_isTargetMet), exp_met ? 32'(oh(exp_grant)) : 32'd0);
    chk("resp_timeout", 32'(resp_timeout), exp_to ? 32'(oh(exp_grant)) : 32'd0);
    chk("respond_en_off", 32'({solver_start, solver_en}), 32'd0);
    if (do_ack) ack_job(exp_grant);
  endtask

  typedef struct {
    int             client;
    logic [NB-1:0]  nums;
    logic [TW-1:0]  tgt;
    int             delay;
    int             hold;
    logic           exp_met;
    logic           exp_to;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // client, numbers, target, delay, hold, met, timeout
    tbl[0] = '{0, pk(9, 5, 2),    7'd14, 6,     0, 1'b1, 1'b0}; // basic
    tbl[1] = '{2, pk(8, 14, 12),  7'd11, 0,     0, 1'b0, 1'b1}; // never done
    tbl[2] = '{1, pk(3, 4, 7),    7'd11, T,     0, 1'b1, 1'b0}; // done on limit
    tbl[3] = '{3, pk(1, 2, 4),    7'd7,  T + 1, 0, 1'b0, 1'b1}; // one too late
    tbl[4] = '{1, pk(3, 4, 7),    7'd12, 5,     3, 1'b0, 1'b0}; // stale done
    tbl[5] = '{3, pk(15, 15, 15), 7'd45, 2,     0, 1'b1, 1'b0}; // max sum
    tbl[6] = '{0, pk(15, 15, 15), 7'd44, 3,     0, 1'b0, 1'b0};
    tbl[7] = '{2, pk(9, 5, 2),    7'd16, 4,     2, 1'b1, 1'b0}; // stale done

    rst              = 1'b1;
    req_valid        = '0;
    req_numbers_flat = '0;
    req_target       = '0;
    resp_ack         = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_outputs", 32'({resp_valid, resp_isTargetMet, resp_timeout, req_ready,
                               solver_start, solver_en, sched_busy}), 32'd0);
    chk("reset_grant_job", 32'({grant_id, solver_numbers_flat, solver_target}), 32'd0);

    // Directed job table
    for (int v = 0; v < 8; v++) begin
      run_job(tbl[v].client, tbl[v].nums, tbl[v].tgt, tbl[v].delay, tbl[v].hold,
              tbl[v].exp_met, tbl[v].exp_to, oh(tbl[v].client), tbl[v].client,
              1'b1, 1'b1);
      @(posedge clk); #1;
    end

    // Round-robin from a fresh pointer with everybody requesting
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 5; k++)
      run_job(k % NR, pk(9, 5, 2), 7'd14, 3, 0, 1'b1, 1'b0, 4'hF, k % NR, 1'b0, 1'b1);
    req_valid = '0;
    @(posedge clk); #1;

    // Backpressure: client 1 holds its result while others request
    run_job(1, pk(8, 14, 12), 7'd22, 3, 0, 1'b1, 1'b0, 4'b0010, 1, 1'b1, 1'b0);
    req_valid = 4'b1101;
    for (int i = 0; i < 20; i++) begin
      resp_ack = (i == 10) ? 4'b0001 : 4'b0000;
      @(posedge clk); #1;
      chk("bp_resp_held", 32'(resp_valid), 32'h2);
      chk("bp_ready_zero", 32'(req_ready), 32'd0);
    end
    resp_ack = '0;
    ack_job(1);
    run_job(2, pk(1, 2, 4), 7'd6, 2, 0, 1'b1, 1'b0, 4'b1101, 2, 1'b1, 1'b1);
    req_valid = '0;
    @(posedge clk); #1;

    // Reset in the middle of WAIT
    sv_delay  = 0;
    sv_hold   = 0;
    req_valid = 4'b0010;
    #1;
    chk("mr_ready", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    chk("mr_launch", 32'(solver_start), 32'd1);
    @(posedge clk); #1;
    chk("mr_wait", 32'({solver_start, solver_en}), 32'h1);
    rst       = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mr_outputs_zero", 32'({resp_valid, req_ready, solver_start, solver_en,
                                 sched_busy, grant_id}), 32'd0);
    chk("mr_job_zero", 32'({solver_numbers_flat, solver_target}), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("mr_no_resp", 32'({resp_valid, sched_busy}), 32'd0);
    end
    run_job(0, pk(2, 3, 5), 7'd8, 4, 0, 1'b1, 1'b0, 4'hF, 0, 1'b1, 1'b1);
    req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
